// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : npu_pkg
//  Purpose  : Shared constants for the CNN accelerator memory top: load-stream
//             region sizes and cumulative beat boundaries, result-map
//             addresses, parameter read selectors and the control FSM states.
//  Revision : 1.0  initial release
// ============================================================================
package npu_pkg;

    localparam int c_cnt_w = 15;
    typedef logic [c_cnt_w-1:0] cnt_t;

    // Region sizes in load beats, in stream order
    localparam int c_img_beats = 224;
    localparam int c_c12_beats = 320;
    localparam int c_c34_beats = 9248;
    localparam int c_c5_beats  = 9247;
    localparam int c_d1_beats  = 4104;
    localparam int c_d2_beats  = 99;

    // Conv5 RAM is one entry deeper than its region; the last entry reads as 0
    localparam int c_c5_depth  = 9248;

    // Cumulative region end boundaries (exclusive) on the beat counter
    localparam cnt_t c_img_end = cnt_t'(c_img_beats);
    localparam cnt_t c_c12_end = c_img_end + cnt_t'(c_c12_beats);
    localparam cnt_t c_c34_end = c_c12_end + cnt_t'(c_c34_beats);
    localparam cnt_t c_c5_end  = c_c34_end + cnt_t'(c_c5_beats);
    localparam cnt_t c_d1_end  = c_c5_end + cnt_t'(c_d1_beats);
    localparam cnt_t c_total   = c_d1_end + cnt_t'(c_d2_beats);

    // Result-bank map
    localparam int c_res_c5_base = 1856;
    localparam int c_idx_addr    = 2409;

    // Parameter read-bus selectors
    localparam logic [2:0] c_sel_img = 3'd0;
    localparam logic [2:0] c_sel_c12 = 3'd1;
    localparam logic [2:0] c_sel_c34 = 3'd2;
    localparam logic [2:0] c_sel_c5  = 3'd3;
    localparam logic [2:0] c_sel_d1  = 3'd4;
    localparam logic [2:0] c_sel_d2  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_READY = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/npu_core.sv
`default_nettype none
// ============================================================================
//  Module   : npu_core
//  Purpose  : Minimal inference core. On start it reads dense1 word 0,
//             stores it byte-reversed at the conv5 flatten base of bank 0,
//             writes class index 7 at the index address, then pulses done.
//  Revision : 1.0  initial release
// ============================================================================
module npu_core
    import npu_pkg::*;
#(
    parameter int RES_AW   = 12,
    parameter int IDX_ADDR = c_idx_addr
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic [2:0]        par_sel,
    output cnt_t              par_addr,
    input  logic [31:0]       par_data,
    output logic [3:0]        res_we,
    output logic [RES_AW-1:0] res_addr,
    output logic [31:0]       res_wdata
);
    localparam logic [2:0] c_step_idle = 3'd0;
    localparam logic [2:0] c_step_last = 3'd6;
    localparam logic [7:0] c_class     = 8'd7;

    logic [2:0] r_step;
    logic [1:0] w_lane;
    logic [7:0] w_byte;

    // Step sequencer: idle until start, then run steps 1..6 once
    always_ff @(posedge clk) begin
        if (reset)                     r_step <= c_step_idle;
        else if (r_step == c_step_idle) r_step <= start ? 3'd1 : c_step_idle;
        else if (r_step == c_step_last) r_step <= c_step_idle;
        else                           r_step <= r_step + 3'd1;
    end

    // Step 1 stores the least significant byte first, so memory order is reversed
    assign w_lane = r_step[1:0] - 2'd1;
    assign w_byte = par_data[{w_lane, 3'b000} +: 8];

    // Per-step read request, result writes and done pulse
    always_comb begin
        par_sel   = c_sel_d1;
        par_addr  = '0;
        res_we    = '0;
        res_addr  = '0;
        res_wdata = '0;
        done      = 1'b0;
        case (r_step)
            3'd1, 3'd2, 3'd3, 3'd4: begin
                res_we    = 4'b0001;
                res_addr  = RES_AW'(c_res_c5_base) + RES_AW'(r_step - 3'd1);
                res_wdata = {24'h0, w_byte};
            end
            3'd5: begin
                res_we    = 4'b0001;
                res_addr  = RES_AW'(IDX_ADDR);
                res_wdata = {24'h0, c_class};
            end
            3'd6:    done = 1'b1;
            default: ;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/npu_mem_top_mem.sv
`default_nettype none
// ============================================================================
//  Module   : npu_ram / memory_read
//  Purpose  : Generic single-write, single-read RAM with a registered read,
//             and the four byte-wide result banks built from it.
//  Revision : 1.0  initial release
// ============================================================================
module npu_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Synchronous write, registered read; contents survive reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

module memory_read #(
    parameter int RES_DEPTH = 4096,
    parameter int AW        = $clog2(RES_DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    // Byte lane n of the write/read buses belongs to bank n
    npu_ram #(.WIDTH(8), .DEPTH(RES_DEPTH)) res_ram0 (.clk, .we(we[0]), .waddr,
        .wdata(wdata[7:0]),   .raddr, .rdata(rdata[7:0]));
    npu_ram #(.WIDTH(8), .DEPTH(RES_DEPTH)) res_ram1 (.clk, .we(we[1]), .waddr,
        .wdata(wdata[15:8]),  .raddr, .rdata(rdata[15:8]));
    npu_ram #(.WIDTH(8), .DEPTH(RES_DEPTH)) res_ram2 (.clk, .we(we[2]), .waddr,
        .wdata(wdata[23:16]), .raddr, .rdata(rdata[23:16]));
    npu_ram #(.WIDTH(8), .DEPTH(RES_DEPTH)) res_ram3 (.clk, .we(we[3]), .waddr,
        .wdata(wdata[31:24]), .raddr, .rdata(rdata[31:24]));
endmodule
`default_nettype wire

// File: rtl/npu_mem_top.sv
`default_nettype none
// ============================================================================
//  Module   : npu_mem_top
//  Purpose  : Streams the fixed-length model image from the host write port
//             into parameter RAMs, launches the core and presents the final
//             class index on D_OUT.
//  Revision : 1.0  initial release
// ============================================================================
module npu_mem_top
    import npu_pkg::*;
#(
    parameter int RES_DEPTH = 4096,
    parameter int IDX_ADDR  = c_idx_addr
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] writedata,
    input  logic [31:0] control_reg,
    output logic [7:0]  D_OUT
);
    localparam int c_res_aw = $clog2(RES_DEPTH);
    localparam int c_img_aw = $clog2(c_img_beats);
    localparam int c_c12_aw = $clog2(c_c12_beats);
    localparam int c_c34_aw = $clog2(c_c34_beats);
    localparam int c_c5_aw  = $clog2(c_c5_depth);
    localparam int c_d1_aw  = $clog2(c_d1_beats);
    localparam int c_d2_aw  = $clog2(c_d2_beats);

    state_t  r_state, w_next;
    cnt_t    r_cnt, w_base, w_loc, w_par_addr;
    logic    w_cap, w_start, w_done, r_dout_ld, r_c5_hole;
    logic [5:0]  w_we;
    logic [2:0]  w_par_sel, r_par_sel;
    logic [31:0] w_img_q, w_d1_q, w_d2_q, w_par_data;
    logic [7:0]  w_c12_q, w_c34_q, w_c5_q;
    logic [3:0]  w_res_we;
    logic [c_res_aw-1:0] w_res_waddr;
    logic [31:0] w_res_wdata, w_res_rdata;
    logic        w_unused;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next state; load enable is only looked at from IDLE/DONE, start only in READY
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (control_reg[0]) w_next = ST_ARM;
            ST_ARM:           w_next = ST_LOAD;
            ST_LOAD:          if (r_cnt == c_total - cnt_t'(1)) w_next = ST_READY;
            ST_READY:         if (control_reg[1]) w_next = ST_RUN;
            ST_RUN:           if (w_done) w_next = ST_DONE;
            default:          w_next = ST_IDLE;
        endcase
    end

    // FSM outputs: capture strobe and single-cycle core start
    always_comb begin
        w_cap   = (r_state == ST_LOAD);
        w_start = (r_state == ST_READY) && control_reg[1];
    end

    // Beat counter, cleared when a new load is armed
    always_ff @(posedge clk) begin
        if (reset)                  r_cnt <= '0;
        else if (r_state == ST_ARM) r_cnt <= '0;
        else if (w_cap)             r_cnt <= r_cnt + cnt_t'(1);
    end

    // Region decode: write enable and region base for the current beat
    always_comb begin
        w_we   = '0;
        w_base = '0;
        if (r_cnt < c_img_end) begin
            w_we[0] = w_cap;
        end else if (r_cnt < c_c12_end) begin
            w_we[1] = w_cap; w_base = c_img_end;
        end else if (r_cnt < c_c34_end) begin
            w_we[2] = w_cap; w_base = c_c12_end;
        end else if (r_cnt < c_c5_end) begin
            w_we[3] = w_cap; w_base = c_c34_end;
        end else if (r_cnt < c_d1_end) begin
            w_we[4] = w_cap; w_base = c_c5_end;
        end else if (r_cnt < c_total) begin
            w_we[5] = w_cap; w_base = c_d1_end;
        end
    end

    assign w_loc = r_cnt - w_base;

    npu_ram #(.WIDTH(32), .DEPTH(c_img_beats)) u_img (.clk, .we(w_we[0]),
        .waddr(w_loc[c_img_aw-1:0]), .wdata(writedata),
        .raddr(w_par_addr[c_img_aw-1:0]), .rdata(w_img_q));
    npu_ram #(.WIDTH(8), .DEPTH(c_c12_beats)) u_c12 (.clk, .we(w_we[1]),
        .waddr(w_loc[c_c12_aw-1:0]), .wdata(writedata[7:0]),
        .raddr(w_par_addr[c_c12_aw-1:0]), .rdata(w_c12_q));
    npu_ram #(.WIDTH(8), .DEPTH(c_c34_beats)) u_c34 (.clk, .we(w_we[2]),
        .waddr(w_loc[c_c34_aw-1:0]), .wdata(writedata[7:0]),
        .raddr(w_par_addr[c_c34_aw-1:0]), .rdata(w_c34_q));
    npu_ram #(.WIDTH(8), .DEPTH(c_c5_depth)) u_c5 (.clk, .we(w_we[3]),
        .waddr(w_loc[c_c5_aw-1:0]), .wdata(writedata[7:0]),
        .raddr(w_par_addr[c_c5_aw-1:0]), .rdata(w_c5_q));
    npu_ram #(.WIDTH(32), .DEPTH(c_d1_beats)) u_d1 (.clk, .we(w_we[4]),
        .waddr(w_loc[c_d1_aw-1:0]), .wdata(writedata),
        .raddr(w_par_addr[c_d1_aw-1:0]), .rdata(w_d1_q));
    npu_ram #(.WIDTH(32), .DEPTH(c_d2_beats)) u_d2 (.clk, .we(w_we[5]),
        .waddr(w_loc[c_d2_aw-1:0]), .wdata(writedata),
        .raddr(w_par_addr[c_d2_aw-1:0]), .rdata(w_d2_q));

    // Track which RAM the core read, aligned with the registered RAM output
    always_ff @(posedge clk) begin
        if (reset) begin
            r_par_sel <= c_sel_img;
            r_c5_hole <= 1'b0;
        end else begin
            r_par_sel <= w_par_sel;
            r_c5_hole <= (w_par_addr == cnt_t'(c_c5_beats));
        end
    end

    // Parameter read mux; the never-loaded last conv5 entry reads as zero
    always_comb begin
        w_par_data = '0;
        case (r_par_sel)
            c_sel_img: w_par_data = w_img_q;
            c_sel_c12: w_par_data = {24'h0, w_c12_q};
            c_sel_c34: w_par_data = {24'h0, w_c34_q};
            c_sel_c5:  w_par_data = r_c5_hole ? 32'h0 : {24'h0, w_c5_q};
            c_sel_d1:  w_par_data = w_d1_q;
            c_sel_d2:  w_par_data = w_d2_q;
            default:   w_par_data = '0;
        endcase
    end

    npu_core #(.RES_AW(c_res_aw), .IDX_ADDR(IDX_ADDR)) u_core (
        .clk, .reset, .start(w_start), .done(w_done),
        .par_sel(w_par_sel), .par_addr(w_par_addr), .par_data(w_par_data),
        .res_we(w_res_we), .res_addr(w_res_waddr), .res_wdata(w_res_wdata));

    memory_read #(.RES_DEPTH(RES_DEPTH)) memory_read1 (
        .clk, .we(w_res_we), .waddr(w_res_waddr), .wdata(w_res_wdata),
        .raddr(c_res_aw'(IDX_ADDR)), .rdata(w_res_rdata));

    // Class index: bank 0 is read on the done edge, registered one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout_ld <= 1'b0;
            D_OUT     <= 8'h00;
        end else begin
            r_dout_ld <= (r_state == ST_RUN) && w_done;
            if (r_dout_ld) D_OUT <= w_res_rdata[7:0];
        end
    end

    assign w_unused = ^{control_reg[31:2], w_res_rdata[31:8]};
endmodule
`default_nettype wire

// File: tb/tb_npu_mem_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_npu_mem_top
//  Purpose  : Directed bench for npu_mem_top: full model load with boundary
//             table, run with class readout, reset mid-load and reload.
//  Revision : 1.0  initial release
// ============================================================================
module tb_npu_mem_top;
    import npu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] writedata;
    logic [31:0] control_reg;
    logic [7:0]  D_OUT;

    int total;
    int bad;

    typedef struct {
        int          ram;
        int          addr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl [12];

    npu_mem_top #(.RES_DEPTH(4096), .IDX_ADDR(2409)) dut (
        .clk(clk), .reset(reset), .writedata(writedata),
        .control_reg(control_reg), .D_OUT(D_OUT));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] peek(input int r, input int a);
        case (r)
            0:       return dut.u_img.mem[a[7:0]];
            1:       return {24'h0, dut.u_c12.mem[a[8:0]]};
            2:       return {24'h0, dut.u_c34.mem[a[13:0]]};
            3:       return {24'h0, dut.u_c5.mem[a[13:0]]};
            4:       return dut.u_d1.mem[a[12:0]];
            5:       return dut.u_d2.mem[a[6:0]];
            default: return 32'h0;
        endcase
    endfunction

    // Arm, stream 23242 beats of (seed | k); optional reset before beat stop_at.
    // Beats 100..199 carry control_reg=2, which must be ignored in LOAD.
    task automatic do_load(input logic [31:0] seed, input int stop_at);
        @(negedge clk); control_reg = 32'd1; writedata = 32'hDEADBEEF;
        @(negedge clk); control_reg = 32'd0;
        for (int k = 0; k < 23242; k++) begin
            @(negedge clk);
            writedata   = seed | 32'(k);
            control_reg = (k >= 100 && k < 200) ? 32'd2 : 32'd0;
            if (k == stop_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                control_reg = 32'd0;
                return;
            end
        end
        repeat (3) begin
            @(negedge clk); control_reg = 32'd1; writedata = 32'hFFFFFFFF;
        end
        @(negedge clk); control_reg = 32'd0;
    endtask

    initial begin
        logic found;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        control_reg = 32'd0;
        writedata   = 32'd0;

        // Hand-computed from writedata = 32'hA5000000 | beat
        tbl[0]  = '{0, 0,    32'hA5000000, "img_0"};
        tbl[1]  = '{0, 223,  32'hA50000DF, "img_223"};
        tbl[2]  = '{1, 0,    32'h000000E0, "c12_0"};
        tbl[3]  = '{1, 319,  32'h0000001F, "c12_319"};
        tbl[4]  = '{2, 0,    32'h00000020, "c34_0"};
        tbl[5]  = '{2, 9247, 32'h0000003F, "c34_9247"};
        tbl[6]  = '{3, 0,    32'h00000040, "c5_0"};
        tbl[7]  = '{3, 9246, 32'h0000005E, "c5_9246"};
        tbl[8]  = '{4, 0,    32'hA5004A5F, "d1_0"};
        tbl[9]  = '{4, 4103, 32'hA5005A66, "d1_4103"};
        tbl[10] = '{5, 0,    32'hA5005A67, "d2_0"};
        tbl[11] = '{5, 98,   32'hA5005AC9, "d2_98"};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_dout", {24'h0, D_OUT}, 32'h0);
        chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));

        // Full load, trailing 0xFFFFFFFF beats must not land anywhere
        do_load(32'hA5000000, -1);
        chk("load_ready", 32'(dut.r_state), 32'(ST_READY));
        for (int i = 0; i < 12; i++)
            chk(tbl[i].name, peek(tbl[i].ram, tbl[i].addr), tbl[i].exp);
        chk("dout_before_run", {24'h0, D_OUT}, 32'h0);

        // Start and wait for the core's done pulse
        @(negedge clk); control_reg = 32'd2;
        @(negedge clk); control_reg = 32'd0;
        chk("run_state", 32'(dut.r_state), 32'(ST_RUN));
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            if (dut.w_done) found = 1'b1;
            else @(negedge clk);
        end
        chk("done_seen", {31'h0, found}, 32'h1);
        chk("dout_at_done", {24'h0, D_OUT}, 32'h0);
        @(negedge clk);
        chk("dout_done_p1", {24'h0, D_OUT}, 32'h0);
        chk("done_state", 32'(dut.r_state), 32'(ST_DONE));
        @(negedge clk);
        chk("dout_done_p2", {24'h0, D_OUT}, 32'h7);
        // dense1 word 0 = A5004A5F stored byte-reversed at 1856..1859
        chk("flat_1856", {24'h0, dut.memory_read1.res_ram0.mem[1856]}, 32'h5F);
        chk("flat_1857", {24'h0, dut.memory_read1.res_ram0.mem[1857]}, 32'h4A);
        chk("flat_1858", {24'h0, dut.memory_read1.res_ram0.mem[1858]}, 32'h00);
        chk("flat_1859", {24'h0, dut.memory_read1.res_ram0.mem[1859]}, 32'hA5);
        chk("idx_2409",  {24'h0, dut.memory_read1.res_ram0.mem[2409]}, 32'h07);
        repeat (3) @(negedge clk);
        chk("dout_hold", {24'h0, D_OUT}, 32'h7);

        // Reload from DONE, aborted by reset at beat 5000
        do_load(32'h3C000000, 5000);
        chk("abort_dout", {24'h0, D_OUT}, 32'h0);
        chk("abort_state", 32'(dut.r_state), 32'(ST_IDLE));
        chk("abort_img_5", peek(0, 5), 32'h3C000005);

        // Fresh load from beat 0
        do_load(32'h5A000000, -1);
        chk("reload_ready", 32'(dut.r_state), 32'(ST_READY));
        chk("reload_img_0", peek(0, 0), 32'h5A000000);
        chk("reload_img_223", peek(0, 223), 32'h5A0000DF);
        chk("reload_d2_98", peek(5, 98), 32'h5A005AC9);
        chk("reload_dout", {24'h0, D_OUT}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
